// File: rtl/unified_store_logic.sv
// Write-back stage for the shared FFT/NTT butterfly: steers results A and B onto two
// single-write-port banks, serializing same-bank collisions through a per-bank FIFO.

module unified_store_bank #(
  parameter int DATA_W     = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_hit,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_hit,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_W-1:0]     wdata,
  output logic                  almost_full,
  output logic                  idle_nxt,
  output logic                  drop
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_WIDTH + DATA_W;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q, count_nxt, space, push_req, push_n;
  logic [ENT_W-1:0] ent_a, ent_b, head, wr_ent, push0, push1;
  logic             pop, wr_valid;

  // Service order: FIFO head, then A, then B. Whatever is not written this cycle is queued.
  always_comb begin
    ent_a    = {a_addr, a_data};
    ent_b    = {b_addr, b_data};
    head     = mem[rd_ptr];
    pop      = (count_q != '0);
    wr_valid = 1'b0;
    wr_ent   = '0;
    push_req = '0;
    push0    = '0;
    push1    = '0;
    if (pop) begin
      wr_valid = 1'b1;
      wr_ent   = head;
      if (a_hit) begin
        push_req = CNT_W'(1);
        push0    = ent_a;
        if (b_hit) begin
          push_req = CNT_W'(2);
          push1    = ent_b;
        end
      end else if (b_hit) begin
        push_req = CNT_W'(1);
        push0    = ent_b;
      end
    end else if (a_hit) begin
      wr_valid = 1'b1;
      wr_ent   = ent_a;
      if (b_hit) begin
        push_req = CNT_W'(1);
        push0    = ent_b;
      end
    end else if (b_hit) begin
      wr_valid = 1'b1;
      wr_ent   = ent_b;
    end
    // The slot freed by this cycle's pop is reusable by this cycle's push.
    space     = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);
    drop      = (push_req > space);
    push_n    = drop ? space : push_req;
    count_nxt = count_q + push_n - CNT_W'(pop);
    idle_nxt  = (count_nxt == '0) && !wr_valid;
  end

  always_ff @(posedge clk) begin
    if (push_n != '0) mem[wr_ptr] <= push0;
    if (push_n == CNT_W'(2)) mem[wr_ptr + PTR_W'(1)] <= push1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PTR_W'(pop);
      wr_ptr  <= wr_ptr + PTR_W'(push_n);
      count_q <= count_nxt;
      we      <= wr_valid;
      if (wr_valid) {waddr, wdata} <= wr_ent;
    end
  end

  assign almost_full = (count_q >= CNT_W'(AF_THRESH));
endmodule

// Handshake: valid-only inputs with no ready; stall_req is the controller's throttle and
// must be honoured within two cycles to avoid drops (sticky overflow records any drop).
module unified_store_logic #(
  parameter int DATA_W     = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic                  a_bank,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  input  logic                  b_bank,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  we_0,
  output logic [ADDR_WIDTH-1:0] waddr_0,
  output logic [DATA_W-1:0]     wdata_0,
  output logic                  we_1,
  output logic [ADDR_WIDTH-1:0] waddr_1,
  output logic [DATA_W-1:0]     wdata_1,
  output logic                  stall_req,
  output logic                  drained,
  output logic                  overflow
);
  logic af_0, af_1, idle_nxt_0, idle_nxt_1, drop_0, drop_1;

  unified_store_bank #(
    .DATA_W(DATA_W), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .AF_THRESH(AF_THRESH)
  ) u_bank_0 (
    .clk(clk), .rst(rst),
    .a_hit(a_valid && !a_bank), .a_addr(a_addr), .a_data(a_data),
    .b_hit(b_valid && !b_bank), .b_addr(b_addr), .b_data(b_data),
    .we(we_0), .waddr(waddr_0), .wdata(wdata_0),
    .almost_full(af_0), .idle_nxt(idle_nxt_0), .drop(drop_0)
  );

  unified_store_bank #(
    .DATA_W(DATA_W), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .AF_THRESH(AF_THRESH)
  ) u_bank_1 (
    .clk(clk), .rst(rst),
    .a_hit(a_valid && a_bank), .a_addr(a_addr), .a_data(a_data),
    .b_hit(b_valid && b_bank), .b_addr(b_addr), .b_data(b_data),
    .we(we_1), .waddr(waddr_1), .wdata(wdata_1),
    .almost_full(af_1), .idle_nxt(idle_nxt_1), .drop(drop_1)
  );

  assign stall_req = af_0 || af_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      drained  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      drained  <= !a_valid && !b_valid && idle_nxt_0 && idle_nxt_1;
      overflow <= overflow || drop_0 || drop_1;
    end
  end
endmodule

// File: tb/tb_unified_store_logic.sv
// Bench for unified_store_logic: per-bank pending-queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_unified_store_logic;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int DEPTH = 4;
  localparam int AF = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_bank, b_valid, b_bank;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          we_0, we_1, stall_req, drained, overflow;
  logic [AW-1:0] waddr_0, waddr_1;
  logic [DW-1:0] wdata_0, wdata_1;

  int errors = 0;
  int checks = 0;

  unified_store_logic #(
    .DATA_W(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_bank(a_bank), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_bank(b_bank), .b_addr(b_addr), .b_data(b_data),
    .we_0(we_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
    .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
    .stall_req(stall_req), .drained(drained), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: every bank keeps one queue of items not yet written.
  item_t pend [2][$];
  item_t exp_item [2];
  logic  exp_we [2];
  logic  exp_ovf, exp_drained, exp_rst, model_live;

  initial begin
    model_live = 1'b0;
    exp_ovf = 1'b0;
    exp_drained = 1'b1;
    exp_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_we[k] = 1'b0;
      exp_item[k] = '0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      exp_rst = 1'b1;
      exp_ovf = 1'b0;
      exp_drained = 1'b1;
      for (int k = 0; k < 2; k++) begin
        pend[k].delete();
        exp_we[k] = 1'b0;
        exp_item[k] = '0;
      end
    end else begin
      exp_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (a_valid && a_bank == 1'(k)) pend[k].push_back('{addr: a_addr, data: a_data});
        if (b_valid && b_bank == 1'(k)) pend[k].push_back('{addr: b_addr, data: b_data});
        exp_we[k] = (pend[k].size() > 0);
        if (exp_we[k]) exp_item[k] = pend[k].pop_front();
        // Anything beyond what the FIFO can hold is lost, newest first.
        while (pend[k].size() > DEPTH) begin
          void'(pend[k].pop_back());
          exp_ovf = 1'b1;
        end
      end
      exp_drained = !a_valid && !b_valid && pend[0].size() == 0 && pend[1].size() == 0
                    && !exp_we[0] && !exp_we[1];
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (model_live) begin
      check("we_0", we_0, exp_we[0]);
      check("we_1", we_1, exp_we[1]);
      if (exp_we[0] || exp_rst) begin
        check("waddr_0", waddr_0, exp_item[0].addr);
        check("wdata_0", wdata_0, exp_item[0].data);
      end
      if (exp_we[1] || exp_rst) begin
        check("waddr_1", waddr_1, exp_item[1].addr);
        check("wdata_1", wdata_1, exp_item[1].data);
      end
      check("stall_req", stall_req, (pend[0].size() >= AF) || (pend[1].size() >= AF));
      check("drained", drained, exp_drained);
      check("overflow", overflow, exp_ovf);
    end
  end

  // driver tasks: called at a negedge, return at the negedge after the sampling edge
  task automatic drive(input logic av, input logic ab, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic bb, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_valid = av; a_bank = ab; a_addr = aa; a_data = ad;
    b_valid = bv; b_bank = bb; b_addr = ba; b_data = bd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic conflict0(input int aa, input int ba);
    drive(1'b1, 1'b0, AW'(aa), DW'(aa), 1'b1, 1'b0, AW'(ba), DW'(ba));
  endtask

  initial begin
    logic [5:0] st_exp;
    int expw[10];
    rst = 1'b1;
    a_valid = 1'b0; a_bank = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_bank = 1'b0; b_addr = '0; b_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_we_0", we_0, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_drained", drained, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    idle();

    // cross-bank pair
    drive(1'b1, 1'b0, AW'(5), DW'(32'hA), 1'b1, 1'b1, AW'(7), DW'(32'hB));
    check("xb_we_0", we_0, 1'b1);
    check("xb_waddr_0", waddr_0, 5);
    check("xb_wdata_0", wdata_0, 32'hA);
    check("xb_we_1", we_1, 1'b1);
    check("xb_waddr_1", waddr_1, 7);
    check("xb_wdata_1", wdata_1, 32'hB);
    idle();
    check("xb_drained", drained, 1'b1);

    // same-bank conflict on bank 1
    drive(1'b1, 1'b1, AW'(3), DW'(32'h11), 1'b1, 1'b1, AW'(4), DW'(32'h22));
    check("sb_t1_we_1", we_1, 1'b1);
    check("sb_t1_waddr_1", waddr_1, 3);
    check("sb_t1_we_0", we_0, 1'b0);
    check("sb_t1_stall", stall_req, 1'b0);
    idle();
    check("sb_t2_we_1", we_1, 1'b1);
    check("sb_t2_waddr_1", waddr_1, 4);
    check("sb_t2_wdata_1", wdata_1, 32'h22);
    check("sb_t2_we_0", we_0, 1'b0);
    check("sb_t2_stall", stall_req, 1'b0);
    repeat (2) idle();

    // three back-to-back conflicts on bank 0: count goes 1,2,3,2,1,0
    st_exp = 6'b001110;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) conflict0(10 + 2 * c, 11 + 2 * c);
      else idle();
      check("b2b_we_0", we_0, 1'b1);
      check("b2b_waddr_0", waddr_0, AW'(10 + c));
      check("b2b_stall", stall_req, st_exp[c]);
    end
    idle();
    check("b2b_done_we_0", we_0, 1'b0);
    check("b2b_overflow", overflow, 1'b0);

    // six conflicts ignoring stall: B5 and B6 are dropped
    expw = '{30, 31, 32, 33, 34, 35, 36, 37, 38, 40};
    for (int c = 0; c < 10; c++) begin
      if (c < 6) conflict0(30 + 2 * c, 31 + 2 * c);
      else idle();
      check("ovf_we_0", we_0, 1'b1);
      check("ovf_waddr_0", waddr_0, AW'(expw[c]));
      if (c == 3) check("ovf_not_yet", overflow, 1'b0);
      if (c == 4) check("ovf_set", overflow, 1'b1);
    end
    idle();
    check("ovf_done_we_0", we_0, 1'b0);

    // reset while FIFO 0 holds three items
    for (int c = 0; c < 3; c++) conflict0(50 + 2 * c, 51 + 2 * c);
    check("pre_rst_overflow", overflow, 1'b1);
    check("pre_rst_stall", stall_req, 1'b1);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_we_0", we_0, 1'b0);
    check("mid_rst_we_1", we_1, 1'b0);
    check("mid_rst_stall", stall_req, 1'b0);
    check("mid_rst_drained", drained, 1'b1);
    check("mid_rst_overflow", overflow, 1'b0);
    for (int c = 0; c < 4; c++) begin
      idle();
      check("post_rst_no_write", we_0, 1'b0);
    end

    // ordering mix
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(20), DW'(20));
    check("mix_t1_we_0", we_0, 1'b1);
    check("mix_t1_waddr_0", waddr_0, 20);
    drive(1'b1, 1'b0, AW'(21), DW'(21), 1'b1, 1'b1, AW'(22), DW'(22));
    check("mix_t2_waddr_0", waddr_0, 21);
    check("mix_t2_we_1", we_1, 1'b1);
    check("mix_t2_waddr_1", waddr_1, 22);
    repeat (2) idle();

    // randomized traffic, sometimes honouring stall_req, with rare resets
    for (int c = 0; c < 600; c++) begin
      logic av, bv;
      av = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 3) != 0);
      if (stall_req && $urandom_range(0, 1) == 1) begin
        av = 1'b0;
        bv = 1'b0;
      end
      rst = ($urandom_range(0, 79) == 0);
      drive(av, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 4095)),
            {$urandom, $urandom, $urandom, $urandom},
            bv, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 4095)),
            {$urandom, $urandom, $urandom, $urandom});
    end
    rst = 1'b0;
    repeat (10) idle();
    check("final_drained", drained, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unified_store_logic.md
# unified_store_logic

Write-back stage for the shared FFT/NTT butterfly datapath, the store-side counterpart of the unified load logic. It accepts the two butterfly results (A and B), each tagged with a destination bank and word address. It steers them onto the two single-write-port BRAM banks. When both results target the same bank in one cycle, the block serializes them through a small per-bank conflict FIFO and raises a stall request to the controller before that FIFO can overflow.

## Interface
Parameters:
- DATA_W, 128, width of one result word ({real, imag} or NTT residue, zero-extended)
- ADDR_WIDTH, 12, word address width per bank
- FIFO_DEPTH, 4, entries per bank conflict FIFO (power of two, ≥2)
- AF_THRESH, 2, occupancy at or above which stall_req asserts

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  result A present this cycle
- a_bank  in  1  destination bank of A
- a_addr  in  ADDR_WIDTH  destination word address of A
- a_data  in  DATA_W  result A
- b_valid, b_bank, b_addr, b_data  in  1/1/ADDR_WIDTH/DATA_W  same fields for result B
- we_0  out  1  bank 0 write enable
- waddr_0  out  ADDR_WIDTH  bank 0 write address
- wdata_0  out  DATA_W  bank 0 write data
- we_1, waddr_1, wdata_1  out  1/ADDR_WIDTH/DATA_W  bank 1 write port
- stall_req  out  1  either FIFO occupancy ≥ AF_THRESH
- drained  out  1  nothing pending anywhere in the block
- overflow  out  1  sticky: a result was dropped

## Operation
- Per bank k (independent, identical logic):
  - Incoming set I_k = {A if a_valid && a_bank==k, B if b_valid && b_bank==k}, always ordered A before B.
  - Service order each cycle: FIFO head first, then I_k in order.
  - Exactly one item per bank per cycle goes to the write register:
    - FIFO non-empty: the head is popped and written.
    - FIFO empty: the first element of I_k is written.
  - All remaining elements of I_k are pushed into FIFO_k in order. Up to 2 pushes and 1 pop can occur in the same cycle.
  - Occupancy update: next_count = count + pushes − pop.
  - Overflow: if pushes exceed FIFO_DEPTH − count + pop, the excess elements (B first, then A) are dropped and overflow is set. overflow stays set until rst.
- Per-bank program order is preserved: no item overtakes an earlier-arrived item to the same bank.
- Cross-bank A/B items are never held; they are written in the cycle after arrival.
- The block performs no address checking. Duplicate addresses are written in arrival order.
- stall_req = (count_0 ≥ AF_THRESH) || (count_1 ≥ AF_THRESH), decoded from the registered counts (no input combinational path).
- drained is a registered flag, set in cycles where all of the following hold: both counts are 0, we_0 = we_1 = 0, and a_valid = b_valid = 0 were sampled on the previous edge.
- Reset (including mid-operation): both FIFOs are emptied, pending items are discarded, and overflow is cleared.
  - Reset values: we_0 = 0, we_1 = 0, waddr_* = 0, wdata_* = 0, stall_req = 0, overflow = 0, drained = 1.

## Timing
- Direct path latency is 1 cycle: an item sampled at edge t drives we_k/waddr_k/wdata_k during cycle t+1.
- A FIFO-held item is written n+1 cycles after arrival, where n is the number of items ahead of it for that bank. For a same-cycle same-bank conflict with an empty FIFO, A is written at t+1 and B at t+2.
- All outputs are registered. we_k is high for exactly one cycle per written item.
- stall_req follows count with 0 extra cycles: it is high in the cycle after the push that reaches AF_THRESH. It deasserts in the cycle after the pop that brings count below AF_THRESH.
- After stall_req rises, the controller may still deliver up to 2 further conflicting cycles. The defaults (AF_THRESH = 2, FIFO_DEPTH = 4) absorb these without overflow.
- drained rises 1 cycle after the last write cycle.

## Test plan
- Cross-bank pair: a(bank0, addr 5, 0xA), b(bank1, addr 7, 0xB) at t. Required: at t+1, we_0 = 1 with waddr_0 = 5, wdata_0 = 0xA, and we_1 = 1 with waddr_1 = 7, wdata_1 = 0xB. At t+2, drained = 1.
- Same-bank conflict: a(bank1, 3, 0x11), b(bank1, 4, 0x22) at t. Required: bank1 writes addr 3 at t+1 and addr 4 at t+2. we_0 stays 0. stall_req stays 0.
- Back-to-back conflicts on bank0 for 3 cycles. Required: stall_req = 1 from the cycle count reaches 2. All 6 items are written in order: A1, B1, A2, B2, A3, B3 at t+1 … t+6. overflow stays 0.
- Six consecutive same-bank conflict cycles, ignoring stall_req. Required: overflow = 1 once a 5th item cannot be held. Dropped items are the latest B/A items. Earlier items are still written in order.
- Reset asserted while FIFO_0 holds 3 items. Required: the next cycle has we_* = 0, stall_req = 0, drained = 1, overflow = 0. No stale writes appear after rst falls.
- Ordering mix: a lone b(bank0) at t, then a(bank0) + b(bank1) at t+1 while FIFO_0 is empty. Required: bank0 writes the t item then the t+1 A item. Bank1 writes at t+2.
